// File: rtl/audio_in_capture.sv
// Audio input capture: fetches samples from the Audio_Controller ADC side, selects or mixes a channel,
// and buffers words in a FIFO that the CPU drains. Also keeps a sticky overflow flag and a peak meter.
//   state   | meaning
//   IDLE    | waiting for capture_enable && audio_in_available
//   ACK     | read_audio_in high; selected word pushed, peak updated
//   WAIT    | one cycle for the controller to refresh audio_in_available
module audio_in_capture #(
    parameter int FIFO_DEPTH = 16,
    parameter int CW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          CLOCK_50,
    input  logic          resetn,
    input  logic          audio_in_available,
    input  logic [31:0]   left_channel_audio_in,
    input  logic [31:0]   right_channel_audio_in,
    output logic          read_audio_in,
    input  logic          capture_enable,
    input  logic [1:0]    channel_mode,
    input  logic          rd_req,
    output logic [31:0]   rd_data,
    output logic          rd_valid,
    output logic [CW-1:0] fifo_count,
    output logic          fifo_empty,
    output logic          fifo_full,
    output logic          overflow,
    input  logic          clear_overflow,
    output logic [31:0]   peak_level,
    input  logic          peak_clear
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   samp_l_q, samp_l_d;
    logic [31:0]   samp_r_q, samp_r_d;
    logic          read_q, read_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          empty_q, empty_d;
    logic          full_q, full_d;
    logic [31:0]   rd_data_q, rd_data_d;
    logic          rd_valid_q, rd_valid_d;
    logic          overflow_q, overflow_d;
    logic [31:0]   peak_q, peak_d;
    logic [31:0]   mem_q [FIFO_DEPTH];

    logic signed [31:0] sl, sr, mix;
    logic [31:0]   word;
    logic [31:0]   mag;
    logic          push_req, push_ok, pop_ok;

    always_comb begin
        sl  = signed'(samp_l_q);
        sr  = signed'(samp_r_q);
        mix = (sl >>> 1) + (sr >>> 1);
        unique case (channel_mode)
            2'b01:   word = samp_r_q;
            2'b10:   word = mix;
            default: word = samp_l_q;
        endcase
        // Most negative value has no positive counterpart, so it saturates.
        if (word == 32'h8000_0000)
            mag = 32'h7FFF_FFFF;
        else if (word[31])
            mag = -word;
        else
            mag = word;
    end

    always_comb begin
        state_d  = state_q;
        samp_l_d = samp_l_q;
        samp_r_d = samp_r_q;
        unique case (state_q)
            ST_IDLE: begin
                if (capture_enable && audio_in_available) begin
                    state_d  = ST_ACK;
                    samp_l_d = left_channel_audio_in;
                    samp_r_d = right_channel_audio_in;
                end
            end
            ST_ACK:  state_d = ST_WAIT;
            ST_WAIT: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        read_d = (state_d == ST_ACK);
    end

    always_comb begin
        push_req   = (state_q == ST_ACK);
        pop_ok     = rd_req && !empty_q;
        // A pop in the same cycle frees the slot the push needs.
        push_ok    = push_req && (!full_q || pop_ok);
        wr_ptr_d   = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d    = count_q;
        if (push_ok && !pop_ok)
            count_d = count_q + 1'b1;
        else if (pop_ok && !push_ok)
            count_d = count_q - 1'b1;
        empty_d    = (count_d == '0);
        full_d     = (count_d == CW'(FIFO_DEPTH));
        rd_data_d  = pop_ok ? mem_q[rd_ptr_q] : rd_data_q;
        rd_valid_d = pop_ok;

        overflow_d = overflow_q;
        if (push_req && !push_ok)
            overflow_d = 1'b1;
        else if (clear_overflow)
            overflow_d = 1'b0;

        peak_d = peak_q;
        if (push_req) begin
            if (peak_clear || mag > peak_q)
                peak_d = mag;
        end else if (peak_clear) begin
            peak_d = '0;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            samp_l_q   <= '0;
            samp_r_q   <= '0;
            read_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            overflow_q <= 1'b0;
            peak_q     <= '0;
        end else begin
            state_q    <= state_d;
            samp_l_q   <= samp_l_d;
            samp_r_q   <= samp_r_d;
            read_q     <= read_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            overflow_q <= overflow_d;
            peak_q     <= peak_d;
        end
    end

    // Storage needs no reset: entries are only visible after being written.
    always_ff @(posedge CLOCK_50) begin
        if (push_ok)
            mem_q[wr_ptr_q] <= word;
    end

    assign read_audio_in = read_q;
    assign rd_data       = rd_data_q;
    assign rd_valid      = rd_valid_q;
    assign fifo_count    = count_q;
    assign fifo_empty    = empty_q;
    assign fifo_full     = full_q;
    assign overflow      = overflow_q;
    assign peak_level    = peak_q;

endmodule

// File: doc/audio_in_capture.md
# audio_in_capture

Capture engine for the audio input path: it drains samples from the Audio_Controller ADC-side interface (`audio_in_available` / `read_audio_in` / `left_channel_audio_in` / `right_channel_audio_in`) and stores a selected or mixed channel in a small FIFO. The CPU pops the FIFO through a simple request/valid port. The block also tracks a sticky overflow flag and a peak-magnitude meter. It is the receive-direction counterpart of the synthesizer output path and sits beside Audio_Controller in the audio top level.

## Interface
- `FIFO_DEPTH`, default 16: number of FIFO entries; must be a power of 2 and at least 2.
- `CW`, default $clog2(FIFO_DEPTH)+1: width of `fifo_count`.
- `CLOCK_50`  in  1  sole clock; all logic is on its rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `audio_in_available`  in  1  Audio_Controller has an input sample ready.
- `left_channel_audio_in`  in  32  signed two's-complement left sample.
- `right_channel_audio_in`  in  32  signed two's-complement right sample.
- `read_audio_in`  out  1  one-cycle acknowledge that consumes the current sample.
- `capture_enable`  in  1  level signal; when 1, new samples are fetched.
- `channel_mode`  in  2  00 left, 01 right, 10 average of L and R, 11 left (reserved).
- `rd_req`  in  1  CPU pop request.
- `rd_data`  out  32  popped sample.
- `rd_valid`  out  1  one-cycle pulse marking `rd_data` as valid.
- `fifo_count`  out  CW  current number of FIFO entries.
- `fifo_empty`  out  1  asserted when `fifo_count` is 0.
- `fifo_full`  out  1  asserted when `fifo_count` equals `FIFO_DEPTH`.
- `overflow`  out  1  sticky: a sample was dropped.
- `clear_overflow`  in  1  clears `overflow`.
- `peak_level`  out  32  maximum magnitude seen since the last clear.
- `peak_clear`  in  1  clears `peak_level`.

## Operation

**FSM states: IDLE, ACK, WAIT.**
- IDLE → ACK when `capture_enable` and `audio_in_available` are both 1. On that edge the block latches L and R into `samp_l` and `samp_r`.
- ACK: `read_audio_in` is 1, the selected word is pushed, and the peak meter is updated. ACK → WAIT unconditionally.
- WAIT: gives the controller one cycle to update `audio_in_available`. WAIT → IDLE unconditionally.
- Deasserting `capture_enable` during ACK or WAIT does not abort; the sample in progress completes.

**Word selection (signed arithmetic):**
- Mode 00 and 11 select L; mode 01 selects R.
- Mode 10 produces (L>>>1)+(R>>>1). This sum cannot overflow.
- `channel_mode` is sampled in the ACK cycle.

**FIFO:**
- Circular buffer with read and write pointers of $clog2(FIFO_DEPTH) bits that wrap at `FIFO_DEPTH`.
- A push is accepted if the FIFO is not full, or if a valid pop occurs in the same cycle.
- If a push is rejected, the word is dropped and `overflow` is set to 1.
- A pop is valid when `rd_req` is 1 and the FIFO is not empty. `rd_req` while empty is ignored: no pointer change and no `rd_valid`.
- Simultaneous accepted push and pop leave `fifo_count` unchanged.

**Overflow flag:**
- Set on a drop. If `clear_overflow` and a drop occur in the same cycle, the set wins.

**Peak meter:**
- mag = |word|, with 0x80000000 saturating to 0x7FFFFFFF.
- On every ACK (including dropped samples), `peak_level` becomes max(`peak_level`, mag).
- If `peak_clear` is 1 in the same ACK cycle, `peak_level` becomes mag. `peak_clear` in any other cycle sets `peak_level` to 0.

**Reset values:**
- FSM in IDLE; pointers 0.
- `read_audio_in`, `rd_valid`, `overflow` = 0; `rd_data` = 0; `peak_level` = 0.
- `fifo_count` = 0, `fifo_empty` = 1, `fifo_full` = 0.
- Reset mid-operation discards FIFO contents and any sample in flight. `read_audio_in` deasserts immediately.

## Timing
- All outputs are registered.
- `audio_in_available` seen high at edge N → `read_audio_in` high for exactly cycle N+1 → `fifo_count` reflects the push from edge N+2.
- Minimum spacing between fetches is 3 cycles; `read_audio_in` is never high in two consecutive cycles.
- `rd_req` sampled at edge M → `rd_data` and `rd_valid` updated at edge M+1, and `fifo_count` decrements at the same edge.
- `rd_data` holds its last popped value when `rd_valid` is 0.
- Back-to-back `rd_req` on every cycle yields one word per cycle.
- Flags follow `fifo_count` in the same cycle.

## Test plan
- **Reset and single fetch:** hold `resetn`=0 → all outputs at reset values. Release; set `capture_enable`=1, mode 00, L=0x00001234, pulse available → exactly one `read_audio_in` pulse one cycle later, `fifo_count`=1. Then `rd_req` → `rd_data`=0x00001234 with `rd_valid` 1 cycle later.
- **Mode mix:** L=0x40000000, R=0x20000000, mode 10 → word 0x30000000. L=0xFFFFFFFE, R=0xFFFFFFFE → 0xFFFFFFFE. Mode 01 → R.
- **Overflow:** 17 samples with no reads (depth 16) → `fifo_full`=1, `overflow`=1, first 16 values read back in order. `clear_overflow` → 0. Drop coincident with clear → `overflow` stays 1.
- **Simultaneous push/pop at full:** `rd_req` in the ACK cycle while full → push accepted, `fifo_count` stays 16, no overflow. Pointer wrap verified over 40 in-order samples.
- **Peak meter:** samples 0x00000100, 0xFFFFF000, 0x80000000 → `peak_level` = 0x100, then 0x1000, then 0x7FFFFFFF. `peak_clear` coincident with sample 0x5 → `peak_level`=5.
- **Mid-operation events:** drop `capture_enable` during ACK → sample still pushed, no further fetches. Assert `resetn`=0 during ACK → `read_audio_in` low immediately, `fifo_count`=0.
